// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read-channel arbiter, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed priority to master 0.

module axi_read_arbiter_port (
  input  logic        ar_sel,
  input  logic        r_sel,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic        s_rvalid,
  input  logic        s_rlast,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        rlast
);
  assign arready = ar_sel & s_arready;
  assign rdata   = r_sel ? s_rdata : '0;
  assign rvalid  = r_sel & s_rvalid;
  assign rlast   = r_sel & s_rlast;
endmodule

module axi_read_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  output logic        m0_rlast,
  input  logic        m0_rready,
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        m1_rlast,
  input  logic        m1_rready,
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic        s_rvalid,
  input  logic        s_rlast,
  output logic        s_rready
);
  typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              gnt, gnt_nxt, pick;
  logic              in_ar, in_r;
  logic [1:0]        req, rready, ar_sel, r_sel, arready, rvalid, rlast;
  logic [1:0][31:0]  araddr, rdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic              lst, lst_nxt;
`endif

  assign req    = {m1_arvalid, m0_arvalid};
  assign rready = {m1_rready, m0_rready};
  assign araddr = {m1_araddr, m0_araddr};

  // Outputs are also gated by rstn so nothing leaks while reset is held.
  assign in_ar = rstn && (state == AR);
  assign in_r  = rstn && (state == R);

`ifdef ARB_ROUND_ROBIN_EN
  assign pick = (req == 2'b11) ? !lst : !req[0];
`else
  assign pick = !req[0];
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      gnt   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lst   <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      lst   <= lst_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
`ifdef ARB_ROUND_ROBIN_EN
    lst_nxt   = lst;
`endif
    case (state)
      IDLE: if (|req) begin
        gnt_nxt   = pick;
        state_nxt = AR;
      end
      AR:   if (s_arready) state_nxt = R;
      R:    if (s_rvalid && s_rready && s_rlast) begin
        state_nxt = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        lst_nxt   = gnt;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s_arvalid = in_ar;
  assign s_araddr  = in_ar ? araddr[gnt] : '0;
  assign s_rready  = in_r & rready[gnt];

  for (genvar i = 0; i < 2; i++) begin : g_port
    localparam logic ID = 1'(i);
    assign ar_sel[i] = in_ar && (gnt == ID);
    assign r_sel[i]  = in_r && (gnt == ID);
    axi_read_arbiter_port u_port (
      .ar_sel    (ar_sel[i]),
      .r_sel     (r_sel[i]),
      .s_arready (s_arready),
      .s_rdata   (s_rdata),
      .s_rvalid  (s_rvalid),
      .s_rlast   (s_rlast),
      .arready   (arready[i]),
      .rdata     (rdata[i]),
      .rvalid    (rvalid[i]),
      .rlast     (rlast[i])
    );
  end

  assign m0_arready = arready[0];
  assign m1_arready = arready[1];
  assign m0_rdata   = rdata[0];
  assign m1_rdata   = rdata[1];
  assign m0_rvalid  = rvalid[0];
  assign m1_rvalid  = rvalid[1];
  assign m0_rlast   = rlast[0];
  assign m1_rlast   = rlast[1];
endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have no parameters; data and address widths fixed at 32.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 m0_araddr / m1_araddr  input  32  read address from master 0 / 1.
REQ-005 m0_arvalid / m1_arvalid  input  1  address valid from master 0 / 1.
REQ-006 m0_arready / m1_arready  output  1  address accepted, to master 0 / 1.
REQ-007 m0_rdata / m1_rdata  output  32  read data to master 0 / 1.
REQ-008 m0_rvalid / m1_rvalid, m0_rlast / m1_rlast  output  1  data valid / final beat, to master 0 / 1.
REQ-009 m0_rready / m1_rready  input  1  data ready from master 0 / 1.
REQ-010 s_araddr  output  32, s_arvalid  output  1, s_arready  input  1  shared-slave address channel.
REQ-011 s_rdata  input  32, s_rvalid  input  1, s_rlast  input  1, s_rready  output  1  shared-slave data channel.

Function
REQ-012 FSM states IDLE, AR, R; one transaction outstanding at a time.
REQ-013 IDLE: if any mX_arvalid, latch grant (REQ-019) into register gnt, go to AR next cycle; else stay.
REQ-014 IDLE: all mX_arready, mX_rvalid, mX_rlast, s_arvalid, s_rready = 0.
REQ-015 AR: s_arvalid = 1; s_araddr = granted master's araddr; m[gnt]_arready = s_arready; other master's arready = 0.
REQ-016 AR -> R on cycle where s_arvalid && s_arready; else stay in AR.
REQ-017 R: m[gnt]_rdata/rvalid/rlast = s_rdata/s_rvalid/s_rlast; s_rready = m[gnt]_rready; non-granted master sees rvalid = rlast = 0, rdata = 0.
REQ-018 R -> IDLE on cycle where s_rvalid && s_rready && s_rlast; multi-beat bursts stay in R until rlast; lst register <= gnt on that cycle.
REQ-019 Grant selection: single requester wins; both requesting -> per Configuration.
REQ-020 Granted master dropping arvalid in AR does not abort; s_arvalid held until accepted.
REQ-021 New requests arriving in AR/R wait; earliest grant for them is the IDLE cycle after R completes (one idle bubble between transactions).
REQ-022 s_araddr = 0 whenever not in AR.
REQ-023 All routing outputs combinational from state, gnt and inputs; latency through arbiter zero cycles beyond state transitions.

Reset
REQ-024 rstn low at posedge clk: state <= IDLE, gnt <= 0, lst <= 1 (master 0 favoured first).
REQ-025 Reset mid-transaction (AR or R) SHALL abandon it immediately; all outputs 0 from the following cycle.
REQ-026 During and after reset, all outputs 0 until a new grant.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: simultaneous requests -> grant master != lst (alternating).
REQ-028 Macro ARB_ROUND_ROBIN_EN undefined: simultaneous requests -> master 0 always wins (fixed priority); lst unused.

Verification
REQ-029 Reset, then m0 only: m0_araddr=0x1000, slave returns 0x000000A5 single beat with rlast -> m0 sees rdata=0x000000A5 rvalid=rlast=1; state IDLE after; m1 outputs stay 0.
REQ-030 Both arvalid in same IDLE cycle, with ARB_ROUND_ROBIN_EN -> m0 served first, m1 second, m0 third across three back-to-back rounds.
REQ-031 Same as REQ-030 without macro -> m0 served all three rounds while m0_arvalid held; m1 served only after m0 drops arvalid.
REQ-032 Slave holds s_arready=0 for 5 cycles in AR -> s_arvalid stays 1 with stable s_araddr=0x2004; m1_arready pulses 1 only on accept cycle.
REQ-033 4-beat burst (rlast on 4th), m1_rready deasserted on beat 2 -> s_rready=0 that cycle; all 4 beats delivered in order 0x11,0x22,0x33,0x44.
REQ-034 rstn asserted during R state -> next cycle state IDLE, s_rready=0, m0_rvalid=m1_rvalid=0; fresh m1 request afterwards completes normally.
